// File: rtl/sdram_req_queue.sv
// rtl/sdram_req_queue.sv - command FIFO plus single-outstanding issue FSM in front of one sdram_arb port; optional counters via SDRAM_REQ_QUEUE_STATS_EN
module sdram_req_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    // client command stream
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_we,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    input  logic [TAG_WIDTH-1:0]  cmd_tag,
    // client response stream
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_we,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [TAG_WIDTH-1:0]  rsp_tag,
    // arbiter port
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_wr,
    output logic                  mem_rd,
    input  logic                  mem_rdy,
    input  logic                  mem_wvalid,
    input  logic                  mem_rvalid,
`ifdef SDRAM_REQ_QUEUE_STATS_EN
    output logic [31:0]           stat_wr_cnt,
    output logic [31:0]           stat_rd_cnt,
    output logic [15:0]           stat_max_wait,
    input  logic [DATA_WIDTH-1:0] mem_read_data
`else
    input  logic [DATA_WIDTH-1:0] mem_read_data
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic                  fifo_we_q    [DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_addr_q  [DEPTH];
    logic [DATA_WIDTH-1:0] fifo_wdata_q [DEPTH];
    logic [TAG_WIDTH-1:0]  fifo_tag_q   [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic push;
    logic pop;

    logic                  head_we;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_wdata;
    logic [TAG_WIDTH-1:0]  head_tag;

    // FSM state, holding registers and registered outputs
    state_t                state_q;
    logic                  hold_we_q;
    logic [TAG_WIDTH-1:0]  hold_tag_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;
    logic                  mem_wr_q;
    logic                  mem_rd_q;
    logic                  rsp_valid_q;
    logic                  rsp_we_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic [TAG_WIDTH-1:0]  rsp_tag_q;

    // cmd_ready depends only on the registered count, never on rsp_ready or mem_*
    assign cmd_ready = (count_q != FULL_CNT);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == S_IDLE) && (count_q != '0);

    assign head_we    = fifo_we_q[rd_ptr_q];
    assign head_addr  = fifo_addr_q[rd_ptr_q];
    assign head_wdata = fifo_wdata_q[rd_ptr_q];
    assign head_tag   = fifo_tag_q[rd_ptr_q];

    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_wdata_q;
    assign mem_wr         = mem_wr_q;
    assign mem_rd         = mem_rd_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_we         = rsp_we_q;
    assign rsp_rdata      = rsp_rdata_q;
    assign rsp_tag        = rsp_tag_q;

    // Next pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO pointer and occupancy registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO payload storage; contents are don't-care until written, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_we_q[wr_ptr_q]    <= cmd_we;
            fifo_addr_q[wr_ptr_q]  <= cmd_addr;
            fifo_wdata_q[wr_ptr_q] <= cmd_wdata;
            fifo_tag_q[wr_ptr_q]   <= cmd_tag;
        end
    end

    // Issue FSM: one command at a time through REQ -> WAIT -> RESP with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            hold_we_q   <= 1'b0;
            hold_tag_q  <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wr_q    <= 1'b0;
            mem_rd_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_tag_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        hold_we_q   <= head_we;
                        hold_tag_q  <= head_tag;
                        mem_addr_q  <= head_addr;
                        mem_wdata_q <= head_we ? head_wdata : '0;
                        mem_wr_q    <= head_we;
                        mem_rd_q    <= !head_we;
                        state_q     <= S_REQ;
                    end
                end
                S_REQ: begin
                    // request held stable until the arbiter samples rdy
                    if (mem_rdy) begin
                        mem_wr_q    <= 1'b0;
                        mem_rd_q    <= 1'b0;
                        mem_wdata_q <= '0;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // only the completion pulse matching the command type counts
                    if (hold_we_q && mem_wvalid) begin
                        rsp_valid_q <= 1'b1;
                        rsp_we_q    <= 1'b1;
                        rsp_tag_q   <= hold_tag_q;
                        rsp_rdata_q <= '0;
                        state_q     <= S_RESP;
                    end else if (!hold_we_q && mem_rvalid) begin
                        rsp_valid_q <= 1'b1;
                        rsp_we_q    <= 1'b0;
                        rsp_tag_q   <= hold_tag_q;
                        rsp_rdata_q <= mem_read_data;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SDRAM_REQ_QUEUE_STATS_EN
    logic [15:0] wait_cnt_q;
    logic [15:0] wait_inc;
    logic        wait_done;
    logic [31:0] stat_wr_q;
    logic [31:0] stat_rd_q;
    logic [15:0] stat_max_q;

    assign stat_wr_cnt   = stat_wr_q;
    assign stat_rd_cnt   = stat_rd_q;
    assign stat_max_wait = stat_max_q;

    // Saturating cycle count including the current REQ/WAIT cycle
    always_comb begin
        wait_inc  = (wait_cnt_q == 16'hFFFF) ? 16'hFFFF : wait_cnt_q + 16'd1;
        wait_done = (state_q == S_WAIT) &&
                    ((hold_we_q && mem_wvalid) || (!hold_we_q && mem_rvalid));
    end

    // REQ+WAIT residency per command and accepted-response counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= '0;
            stat_wr_q  <= '0;
            stat_rd_q  <= '0;
            stat_max_q <= '0;
        end else begin
            if (pop) begin
                wait_cnt_q <= '0;
            end else if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
                wait_cnt_q <= wait_inc;
            end
            if (wait_done && (wait_inc > stat_max_q)) begin
                stat_max_q <= wait_inc;
            end
            if (rsp_valid_q && rsp_ready) begin
                if (rsp_we_q) begin
                    stat_wr_q <= stat_wr_q + 32'd1;
                end else begin
                    stat_rd_q <= stat_rd_q + 32'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_sdram_req_queue.sv
// tb/tb_sdram_req_queue.sv - self-checking bench: arbiter/controller responder, scoreboard and directed/random steps
module tb_sdram_req_queue;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int TW    = 4;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic [TW-1:0] cmd_tag;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_we;
    logic [DW-1:0] rsp_rdata;
    logic [TW-1:0] rsp_tag;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_write_data;
    logic          mem_wr;
    logic          mem_rd;
    logic          mem_rdy;
    logic          mem_wvalid;
    logic          mem_rvalid;
    logic [DW-1:0] mem_read_data;
`ifdef SDRAM_REQ_QUEUE_STATS_EN
    logic [31:0]   stat_wr_cnt;
    logic [31:0]   stat_rd_cnt;
    logic [15:0]   stat_max_wait;
`endif

    sdram_req_queue #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_tag(cmd_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_we(rsp_we),
        .rsp_rdata(rsp_rdata), .rsp_tag(rsp_tag),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_rdy(mem_rdy),
        .mem_wvalid(mem_wvalid), .mem_rvalid(mem_rvalid),
`ifdef SDRAM_REQ_QUEUE_STATS_EN
        .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt), .stat_max_wait(stat_max_wait),
`endif
        .mem_read_data(mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nerr = 0;
    int nchk = 0;
    int pushed = 0;
    int rcvd = 0;

    logic hold_rdy = 1'b0;
    logic rsp_hold = 1'b0;
    logic rsp_rand = 1'b1;

    typedef struct {
        logic          we;
        logic [TW-1:0] tag;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t          expq[$];
    logic [DW-1:0] ref_mem   [logic [AW-1:0]];
    logic [DW-1:0] slave_mem [logic [AW-1:0]];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    function automatic logic [DW-1:0] slave_rd(input logic [AW-1:0] a);
        return slave_mem.exists(a) ? slave_mem[a] : '0;
    endfunction

    // Called at a negedge; returns at the negedge after the accepting posedge
    task automatic push(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [TW-1:0] t);
        exp_t e;
        int   n = 0;
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_tag   = t;
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept", cmd_ready, 1);
        if (cmd_ready) begin
            @(posedge clk);
            e.we    = we;
            e.tag   = t;
            e.rdata = we ? '0 : ref_rd(a);
            if (we) ref_mem[a] = d;
            expq.push_back(e);
            pushed++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", expq.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    // Arbiter/controller responder: random rdy delay, random completion delay,
    // stray completion pulses of the wrong type, and request stability checks
    initial begin : slave
        int            sstate = 0;
        int            cnt = 0;
        logic          s_we = 1'b0;
        logic [AW-1:0] s_addr = '0;
        logic [DW-1:0] s_wd = '0;
        logic          preq = 1'b0;
        logic          prdy = 1'b0;
        logic          pwr = 1'b0;
        logic          prd = 1'b0;
        logic [AW-1:0] paddr = '0;
        logic [DW-1:0] pwd = '0;
        mem_rdy       = 1'b0;
        mem_wvalid    = 1'b0;
        mem_rvalid    = 1'b0;
        mem_read_data = '0;
        forever begin
            @(negedge clk);
            mem_wvalid = 1'b0;
            mem_rvalid = 1'b0;
            if (rst) begin
                sstate  = 0;
                mem_rdy = 1'b0;
                preq    = 1'b0;
                continue;
            end
            check("wr_rd_exclusive", mem_wr & mem_rd, 0);
            if (preq && !prdy) begin
                check("req_hold_addr", mem_addr, paddr);
                check("req_hold_wdata", mem_write_data, pwd);
                check("req_hold_wr", mem_wr, pwr);
                check("req_hold_rd", mem_rd, prd);
            end
            case (sstate)
                0: begin
                    if ((mem_wr | mem_rd) && !hold_rdy) begin
                        s_we   = mem_wr;
                        s_addr = mem_addr;
                        s_wd   = mem_write_data;
                        if (mem_rd) check("rd_wdata_zero", mem_write_data, 0);
                        cnt = $urandom_range(0, 2);
                        if (cnt == 0) begin
                            mem_rdy = 1'b1;
                            sstate  = 2;
                        end else begin
                            sstate = 1;
                        end
                    end
                end
                1: begin
                    if (cnt > 1) cnt--;
                    else begin
                        mem_rdy = 1'b1;
                        sstate  = 2;
                    end
                end
                2: begin
                    mem_rdy = 1'b0;
                    check("req_drop", mem_wr | mem_rd, 0);
                    check("wdata_cleared", mem_write_data, 0);
                    if (s_we) slave_mem[s_addr] = s_wd;
                    cnt    = $urandom_range(0, 3);
                    sstate = 3;
                end
                default: begin
                    if (cnt == 0) begin
                        if (s_we) mem_wvalid = 1'b1;
                        else begin
                            mem_read_data = slave_rd(s_addr);
                            mem_rvalid    = 1'b1;
                        end
                        sstate = 0;
                    end else begin
                        cnt--;
                        if ($urandom_range(0, 1) == 1) begin
                            if (s_we) begin
                                mem_read_data = $urandom;
                                mem_rvalid    = 1'b1;
                            end else begin
                                mem_wvalid = 1'b1;
                            end
                        end
                    end
                end
            endcase
            preq  = mem_wr | mem_rd;
            prdy  = mem_rdy;
            pwr   = mem_wr;
            prd   = mem_rd;
            paddr = mem_addr;
            pwd   = mem_write_data;
        end
    end

    // Response consumer with scoreboard and stability checks under backpressure
    initial begin : consumer
        exp_t          e;
        logic          pv = 1'b0;
        logic          p_we = 1'b0;
        logic [TW-1:0] p_tag = '0;
        logic [DW-1:0] p_rdata = '0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pv        = 1'b0;
                rsp_ready = 1'b0;
                continue;
            end
            if (rsp_valid && pv) begin
                check("rsp_hold_we", rsp_we, p_we);
                check("rsp_hold_tag", rsp_tag, p_tag);
                check("rsp_hold_rdata", rsp_rdata, p_rdata);
            end
            rsp_ready = rsp_hold ? 1'b0 : (rsp_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
            if (rsp_valid && rsp_ready) begin
                if (expq.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 0);
                end else begin
                    e = expq.pop_front();
                    check("rsp_we", rsp_we, e.we);
                    check("rsp_tag", rsp_tag, e.tag);
                    check("rsp_rdata", rsp_rdata, e.rdata);
                    rcvd++;
                end
                pv = 1'b0;
            end else if (rsp_valid) begin
                pv      = 1'b1;
                p_we    = rsp_we;
                p_tag   = rsp_tag;
                p_rdata = rsp_rdata;
            end else begin
                pv = 1'b0;
            end
        end
    end

`ifdef SDRAM_REQ_QUEUE_STATS_EN
    int meas_max = 0;
    // Measures cycles from first request cycle up to (not including) rsp_valid
    initial begin : wait_meter
        logic busy = 1'b0;
        int   wc = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy     = 1'b0;
                meas_max = 0;
                continue;
            end
            if (!busy && (mem_wr | mem_rd)) begin
                busy = 1'b1;
                wc   = 0;
            end
            if (busy) begin
                if (rsp_valid) begin
                    if (wc > meas_max) meas_max = wc;
                    busy = 1'b0;
                end else begin
                    wc++;
                end
            end
        end
    end
`endif

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1);
    end

    initial begin : main
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        int            n;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_tag   = '0;

        // reset state
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_rd", mem_rd, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_write_data, 0);
        check("rst_rsp_tag", rsp_tag, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // single write then read
        push(1'b1, 32'h100, 32'hDEADBEEF, 4'd1);
        push(1'b0, 32'h100, $urandom, 4'd2);
        drain();

        // back-to-back burst against a stalled arbiter
        hold_rdy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            push(i[0] ? 1'b0 : 1'b1, 32'h200 + 32'(4 * (i / 2)), $urandom, TW'(i));
            if (i == 3) check("burst_ready_after4", cmd_ready, 1);
        end
        check("burst_full_after5", cmd_ready, 0);
        repeat (6) begin
            @(negedge clk);
            check("burst_full_hold", cmd_ready, 0);
            check("burst_wr_held", mem_wr, 1);
        end
        hold_rdy = 1'b0;
        push(1'b0, 32'h204, $urandom, 4'd5);
        drain();

        // response backpressure
        rsp_rand = 1'b0;
        rsp_hold = 1'b1;
        push(1'b1, 32'h300, $urandom, 4'd9);
        push(1'b0, 32'h300, $urandom, 4'd10);
        push(1'b1, 32'h304, $urandom, 4'd11);
        n = 0;
        while (!rsp_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("bp_rsp_seen", rsp_valid, 1);
        repeat (20) begin
            @(negedge clk);
            check("bp_no_issue", mem_wr | mem_rd, 0);
            check("bp_rsp_valid_held", rsp_valid, 1);
        end
        @(posedge clk);
        #1 rsp_hold = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (mem_wr | mem_rd) break;
        end
        check("bp_reissue_latency", mem_wr | mem_rd, 1);
        drain();
        rsp_rand = 1'b1;

        // wrap-around with random addresses and data
        for (int i = 0; i < 3 * DEPTH + 1; i++) begin
            a = (32'($urandom) & 32'hFFFF_F000) | 32'(i << 4);
            d = $urandom;
            push(1'b1, a, d, TW'(2 * i));
            push(1'b0, a, $urandom, TW'(2 * i + 1));
        end
        drain();
        check("wrap_rsp_count", rcvd, pushed);

        // asynchronous reset while a read is held in REQ
        hold_rdy = 1'b1;
        push(1'b0, 32'h500, $urandom, 4'd7);
        n = 0;
        while (!mem_rd && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rst_pre_mem_rd", mem_rd, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_mem_rd", mem_rd, 0);
        check("arst_mem_wr", mem_wr, 0);
        check("arst_rsp_valid", rsp_valid, 0);
        check("arst_cmd_ready", cmd_ready, 1);
        expq.delete();
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        hold_rdy = 1'b0;
        @(negedge clk);
        d = $urandom;
        push(1'b1, 32'h600, d, 4'd3);
        push(1'b0, 32'h600, $urandom, 4'd4);
        drain();

`ifdef SDRAM_REQ_QUEUE_STATS_EN
        // two writes and one read more: 3 writes / 2 reads since reset
        push(1'b1, 32'h700, $urandom, 4'd12);
        push(1'b0, 32'h700, $urandom, 4'd13);
        push(1'b1, 32'h704, $urandom, 4'd14);
        drain();
        check("stat_wr_cnt", stat_wr_cnt, 3);
        check("stat_rd_cnt", stat_rd_cnt, 2);
        check("stat_max_wait", stat_max_wait, meas_max);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
